// File: rtl/if_prefetch_unit_if.sv
// rtl/if_prefetch_unit_if.sv - run-control, instruction-memory and ID-side bundle of the prefetch unit
interface if_prefetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  stop;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic                  im_rd;
    logic [DATA_WIDTH-1:0] im_r_data;
    logic                  stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [ADDR_WIDTH-1:0] if_pc;

    modport master (
        input  start, im_r_data, stall, redirect_valid, redirect_pc,
        output stop, im_addr, im_rd, if_valid, if_instr, if_pc
    );

    modport slave (
        output start, im_r_data, stall, redirect_valid, redirect_pc,
        input  stop, im_addr, im_rd, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction prefetch FIFO with run control, redirect flush and HALT detection
module if_prefetch_unit #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    OP_WIDTH    = 4,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [OP_WIDTH-1:0]   HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    if_prefetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic [DATA_WIDTH-1:0] r_instr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem    [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic          w_active;
    logic          w_redirect;
    logic          w_start;
    logic [CW-1:0] w_occupancy;
    logic          w_issue;
    logic          w_push;
    logic          w_halt_seen;
    logic          w_valid;
    logic          w_pop;

    assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_redirect  = bus.redirect_valid && w_active;
    assign w_start     = bus.start && ((r_state == S_IDLE) || (r_state == S_HALT));
    // Counting the outstanding fetch as occupied guarantees its response always has a slot.
    assign w_occupancy = r_count + CW'(r_inflight);
    assign w_issue     = (r_state == S_RUN) && !w_redirect && (w_occupancy < CW'(FIFO_DEPTH));
    assign w_push      = r_inflight && (r_state == S_RUN) && !w_redirect;
    assign w_halt_seen = w_push && (bus.im_r_data[DATA_WIDTH-1 -: OP_WIDTH] == HALT_OPCODE);
    assign w_valid     = w_active && (r_count != '0);
    assign w_pop       = w_valid && !bus.stall && !w_redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_halt_seen && !w_redirect) w_state_next = S_DRAIN;
            // Nothing is pushed after the HALT entry, so the last pop is the HALT itself.
            S_DRAIN: if (w_redirect) w_state_next = S_RUN;
                     else if (w_pop && (r_count == CW'(1))) w_state_next = S_HALT;
            S_HALT:  if (bus.start) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else if (w_start || w_redirect) begin
            r_pc       <= w_start ? '0 : bus.redirect_pc;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 1'b1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= bus.im_r_data;
            r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    assign bus.stop     = (r_state == S_HALT);
    assign bus.im_rd    = w_issue;
    assign bus.im_addr  = w_issue ? r_pc : '0;
    assign bus.if_valid = w_valid;
    assign bus.if_instr = w_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign bus.if_pc    = w_valid ? r_pc_mem[r_rd_ptr] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));
endmodule
